// File: rtl/wl_xfer_pkg.sv
// wl_xfer_pkg -- shared types and helpers for the register-transfer sequencer.
//   src_e            : transfer source code (NONE, A, L, Q, Z, G, U, C)
//   DST_*            : bit positions inside the 6-bit destination mask {G,B,Z,Q,L,A}
//   state_e          : sequencer states IDLE -> CLR -> RD -> WR
//   FAIR_LIMIT       : consecutive CT grants tolerated while SQ waits
//   src_dst_overlap  : destination bit that names the same register as a source
//   src_rd_onehot    : active-high read-gate select for a source
// Optional feature macro used by the arbiter: WL_XFER_FAIRNESS_EN.
package wl_xfer_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_A    = 3'd1,
        SRC_L    = 3'd2,
        SRC_Q    = 3'd3,
        SRC_Z    = 3'd4,
        SRC_G    = 3'd5,
        SRC_U    = 3'd6,
        SRC_C    = 3'd7
    } src_e;

    localparam int unsigned DST_A = 0;
    localparam int unsigned DST_L = 1;
    localparam int unsigned DST_Q = 2;
    localparam int unsigned DST_Z = 3;
    localparam int unsigned DST_B = 4;
    localparam int unsigned DST_G = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_RD,
        ST_WR
    } state_e;

    localparam int unsigned FAIR_LIMIT = 3;

    // A destination that is also the source must not be cleared before it is read.
    // U, C and NONE have no destination counterpart.
    function automatic logic [5:0] src_dst_overlap(input src_e src);
        logic [5:0] m;
        m = '0;
        case (src)
            SRC_A:   m[DST_A] = 1'b1;
            SRC_L:   m[DST_L] = 1'b1;
            SRC_Q:   m[DST_Q] = 1'b1;
            SRC_Z:   m[DST_Z] = 1'b1;
            SRC_G:   m[DST_G] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Read gate order is {C,U,G,Z,Q,L,A}; NONE selects nothing so a zero word moves.
    function automatic logic [6:0] src_rd_onehot(input src_e src);
        logic [6:0] m;
        case (src)
            SRC_A:   m = 7'h01;
            SRC_L:   m = 7'h02;
            SRC_Q:   m = 7'h04;
            SRC_Z:   m = 7'h08;
            SRC_G:   m = 7'h10;
            SRC_U:   m = 7'h20;
            SRC_C:   m = 7'h40;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wl_xfer_arb.sv
// wl_xfer_arb -- two-way priority arbiter for the transfer sequencer.
// CT (counter-increment) beats SQ (instruction sequencer). With
// WL_XFER_FAIRNESS_EN defined, a 2-bit streak counter tracks consecutive CT
// wins while SQ is waiting; once it reaches FAIR_LIMIT the next grant is
// forced to SQ. Without the macro the arbiter is strict priority and has no
// state (clock/reset ports are then absent).
// Ports:
//   clk_i, rst_ni   clock / async active-low reset (fairness build only)
//   sample_i        high at a grant point; grants and counter updates only then
//   sq_req_i        SQ request
//   ct_req_i        CT request
//   sq_gnt_o        SQ wins this grant point (combinational)
//   ct_gnt_o        CT wins this grant point (combinational)
module wl_xfer_arb
    import wl_xfer_pkg::*;
(
`ifdef WL_XFER_FAIRNESS_EN
    input  logic clk_i,
    input  logic rst_ni,
`endif
    input  logic sample_i,
    input  logic sq_req_i,
    input  logic ct_req_i,
    output logic sq_gnt_o,
    output logic ct_gnt_o
);

`ifdef WL_XFER_FAIRNESS_EN
    logic [1:0] streak_q, streak_d;
    logic       force_sq;

    always_comb begin
        force_sq = sq_req_i && (streak_q == 2'(FAIR_LIMIT));
        ct_gnt_o = sample_i && ct_req_i && !force_sq;
        sq_gnt_o = sample_i && sq_req_i && !ct_gnt_o;
        streak_d = streak_q;
        if (sample_i) begin
            // Only a CT win with SQ left waiting extends the streak; any other
            // outcome (SQ win, SQ idle) restarts it.
            if (ct_gnt_o && sq_req_i) begin
                streak_d = streak_q + 2'd1;
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    always_comb begin
        ct_gnt_o = sample_i && ct_req_i;
        sq_gnt_o = sample_i && sq_req_i && !ct_req_i;
    end
`endif

endmodule

// File: rtl/wl_xfer_seq.sv
// wl_xfer_seq -- register-transfer sequencer for the four-bit arithmetic slices.
// Accepts one transfer (source register -> destination set) at a time from
// the CT or SQ requester and plays out CLR -> RD -> WR(HOLD_CYCLES) on the
// slice gates. All outputs are registered.
// Optional feature: WL_XFER_FAIRNESS_EN enables the anti-starvation streak
// counter in wl_xfer_arb; undefined gives strict CT priority.
// Parameters:
//   HOLD_CYCLES   write-gate hold length, 1..4
// Ports:
//   CLOCK                 clock, rising edge
//   rst                   asynchronous active-low reset
//   SQ_REQ/SRC/DST, SQ_ACK  instruction-sequencer request, source, dest mask, grant pulse
//   CT_REQ/SRC/DST, CT_ACK  counter-increment request (priority), same layout
//   R_GATES_[6:0]         {RCG_,RUG_,RGG_,RZG_,RQG_,RLG_,RAG_} active low
//   W_GATES_[5:0]         {WG1G_,WBG_,WZG_,WQG_,WLG_,WAG_} active low
//   C_GATES[5:0]          {CGG,CBG,CZG,CQG,CLG1G,CAG} active high
//   BUSY                  high whenever not IDLE
module wl_xfer_seq
    import wl_xfer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       SQ_REQ,
    input  logic [2:0] SQ_SRC,
    input  logic [5:0] SQ_DST,
    output logic       SQ_ACK,
    input  logic       CT_REQ,
    input  logic [2:0] CT_SRC,
    input  logic [5:0] CT_DST,
    output logic       CT_ACK,
    output logic [6:0] R_GATES_,
    output logic [5:0] W_GATES_,
    output logic [5:0] C_GATES,
    output logic       BUSY
);

    localparam logic [1:0] HOLD_LOAD = 2'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    src_e       src_q, src_d;
    logic [5:0] dst_q, dst_d;
    logic [1:0] hold_q, hold_d;
    logic       sq_ack_q, sq_ack_d;
    logic       ct_ack_q, ct_ack_d;
    logic [6:0] r_q, r_d;
    logic [5:0] w_q, w_d;
    logic [5:0] c_q, c_d;
    logic       busy_q, busy_d;

    logic       sample;
    logic       sq_gnt, ct_gnt;

    assign sample = (state_q == ST_IDLE) || ((state_q == ST_WR) && (hold_q == 2'd0));

    wl_xfer_arb u_arb (
`ifdef WL_XFER_FAIRNESS_EN
        .clk_i    (CLOCK),
        .rst_ni   (rst),
`endif
        .sample_i (sample),
        .sq_req_i (SQ_REQ),
        .ct_req_i (CT_REQ),
        .sq_gnt_o (sq_gnt),
        .ct_gnt_o (ct_gnt)
    );

    // Next state, latched transfer and acks.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        hold_d   = hold_q;
        sq_ack_d = 1'b0;
        ct_ack_d = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CLR:  state_d = ST_RD;
            ST_RD: begin
                state_d = ST_WR;
                hold_d  = HOLD_LOAD;
            end
            ST_WR: begin
                if (hold_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Grants are only non-zero at grant points, so they override the
        // IDLE/end-of-WR default above and chain straight into CLR.
        if (ct_gnt) begin
            state_d  = ST_CLR;
            src_d    = src_e'(CT_SRC);
            dst_d    = CT_DST;
            ct_ack_d = 1'b1;
        end else if (sq_gnt) begin
            state_d  = ST_CLR;
            src_d    = src_e'(SQ_SRC);
            dst_d    = SQ_DST;
            sq_ack_d = 1'b1;
        end
    end

    // Gate values are decoded from the next state so they can be registered
    // and appear in the same cycle as the state they belong to.
    always_comb begin
        r_d    = '1;
        w_d    = '1;
        c_d    = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_CLR: c_d = dst_d & ~src_dst_overlap(src_d);
            ST_RD:  r_d = ~src_rd_onehot(src_d);
            ST_WR: begin
                r_d = ~src_rd_onehot(src_d);
                w_d = ~dst_d;
            end
            default: begin
                r_d = '1;
                w_d = '1;
                c_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_NONE;
            dst_q    <= '0;
            hold_q   <= '0;
            sq_ack_q <= 1'b0;
            ct_ack_q <= 1'b0;
            r_q      <= '1;
            w_q      <= '1;
            c_q      <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            hold_q   <= hold_d;
            sq_ack_q <= sq_ack_d;
            ct_ack_q <= ct_ack_d;
            r_q      <= r_d;
            w_q      <= w_d;
            c_q      <= c_d;
            busy_q   <= busy_d;
        end
    end

    assign SQ_ACK   = sq_ack_q;
    assign CT_ACK   = ct_ack_q;
    assign R_GATES_ = r_q;
    assign W_GATES_ = w_q;
    assign C_GATES  = c_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_wl_xfer_seq.sv
// tb_wl_xfer_seq -- scoreboard bench for wl_xfer_seq.
// Requester drivers pop from per-port request queues; expected transfers are
// pushed (in grant order) to a scoreboard that a negedge monitor consumes
// each time an ACK appears. Honors WL_XFER_FAIRNESS_EN for grant order.
module tb_wl_xfer_seq;

    localparam int unsigned HOLD = 1;

    logic       CLOCK = 1'b0;
    logic       rst;
    logic       SQ_REQ, CT_REQ;
    logic [2:0] SQ_SRC, CT_SRC;
    logic [5:0] SQ_DST, CT_DST;
    logic       SQ_ACK, CT_ACK;
    logic [6:0] R_GATES_;
    logic [5:0] W_GATES_;
    logic [5:0] C_GATES;
    logic       BUSY;

    wl_xfer_seq #(.HOLD_CYCLES(HOLD)) dut (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .SQ_REQ   (SQ_REQ),
        .SQ_SRC   (SQ_SRC),
        .SQ_DST   (SQ_DST),
        .SQ_ACK   (SQ_ACK),
        .CT_REQ   (CT_REQ),
        .CT_SRC   (CT_SRC),
        .CT_DST   (CT_DST),
        .CT_ACK   (CT_ACK),
        .R_GATES_ (R_GATES_),
        .W_GATES_ (W_GATES_),
        .C_GATES  (C_GATES),
        .BUSY     (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [2:0] src;
        logic [5:0] dst;
    } req_t;

    typedef struct {
        string      nm;
        bit         is_ct;
        bit         b2b;
        logic [5:0] c;
        logic [6:0] r;
        logic [5:0] w;
    } exp_t;

    req_t ct_q[$];
    req_t sq_q[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ct_st    = 0;
    int sq_st    = 0;
    bit mon_idle = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_ct(input logic [2:0] s, input logic [5:0] d);
        ct_q.push_back('{src: s, dst: d});
    endtask

    task automatic push_sq(input logic [2:0] s, input logic [5:0] d);
        sq_q.push_back('{src: s, dst: d});
    endtask

    task automatic expect_xfer(input string nm, input bit is_ct, input bit b2b,
                               input logic [5:0] c, input logic [6:0] r, input logic [5:0] w);
        exp_t e;
        e.nm = nm; e.is_ct = is_ct; e.b2b = b2b; e.c = c; e.r = r; e.w = w;
        exp_q.push_back(e);
    endtask

    function automatic bit all_idle();
        return (exp_q.size() == 0) && mon_idle && (ct_st == 0) && (sq_st == 0)
            && (ct_q.size() == 0) && (sq_q.size() == 0);
    endfunction

    task automatic wait_drain(input string nm);
        int cyc;
        cyc = 0;
        while (!all_idle() && cyc < 300) begin
            @(posedge CLOCK);
            cyc++;
        end
        chk({nm, ".drain"}, 32'(all_idle()), 32'd1);
        repeat (2) @(posedge CLOCK);
    endtask

    // Requester model: hold REQ until ACK is seen, drop at the edge ending the
    // ACK cycle, present the next queued request one cycle later.
    initial begin : ct_drv
        req_t r;
        CT_REQ = 1'b0; CT_SRC = '0; CT_DST = '0;
        forever begin
            @(posedge CLOCK); #1;
            if (ct_st == 2) begin
                CT_REQ = 1'b0; ct_st = 0;
            end else if (ct_st == 1) begin
                if (CT_ACK) ct_st = 2;
            end else if (ct_q.size() != 0) begin
                r = ct_q.pop_front();
                CT_SRC = r.src; CT_DST = r.dst; CT_REQ = 1'b1; ct_st = 1;
            end
        end
    end

    initial begin : sq_drv
        req_t r;
        SQ_REQ = 1'b0; SQ_SRC = '0; SQ_DST = '0;
        forever begin
            @(posedge CLOCK); #1;
            if (sq_st == 2) begin
                SQ_REQ = 1'b0; sq_st = 0;
            end else if (sq_st == 1) begin
                if (SQ_ACK) sq_st = 2;
            end else if (sq_q.size() != 0) begin
                r = sq_q.pop_front();
                SQ_SRC = r.src; SQ_DST = r.dst; SQ_REQ = 1'b1; sq_st = 1;
            end
        end
    end

    // Monitor: every ACK starts one transfer; check CLR, RD and WR cycles.
    initial begin : monitor
        exp_t e;
        int   idle_cyc;
        idle_cyc = 0;
        forever begin
            @(negedge CLOCK);
            if (SQ_ACK || CT_ACK) begin
                mon_idle = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got sq=%0b ct=%0b, expected none at %0t",
                             SQ_ACK, CT_ACK, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, ".ct_ack"}, 32'(CT_ACK), 32'(e.is_ct));
                    chk({e.nm, ".sq_ack"}, 32'(SQ_ACK), 32'(!e.is_ct));
                    if (e.b2b) chk({e.nm, ".idle_gap"}, 32'(idle_cyc), 32'd0);
                    chk({e.nm, ".clr.c"}, 32'(C_GATES), 32'(e.c));
                    chk({e.nm, ".clr.r"}, 32'(R_GATES_), 32'h7F);
                    chk({e.nm, ".clr.w"}, 32'(W_GATES_), 32'h3F);
                    chk({e.nm, ".clr.busy"}, 32'(BUSY), 32'd1);
                    @(negedge CLOCK);
                    chk({e.nm, ".rd.r"}, 32'(R_GATES_), 32'(e.r));
                    chk({e.nm, ".rd.w"}, 32'(W_GATES_), 32'h3F);
                    chk({e.nm, ".rd.c"}, 32'(C_GATES), 32'h0);
                    chk({e.nm, ".rd.acks"}, 32'({SQ_ACK, CT_ACK}), 32'h0);
                    chk({e.nm, ".rd.busy"}, 32'(BUSY), 32'd1);
                    for (int unsigned i = 0; i < HOLD; i++) begin
                        @(negedge CLOCK);
                        chk({e.nm, ".wr.r"}, 32'(R_GATES_), 32'(e.r));
                        chk({e.nm, ".wr.w"}, 32'(W_GATES_), 32'(e.w));
                        chk({e.nm, ".wr.c"}, 32'(C_GATES), 32'h0);
                        chk({e.nm, ".wr.acks"}, 32'({SQ_ACK, CT_ACK}), 32'h0);
                        chk({e.nm, ".wr.busy"}, 32'(BUSY), 32'd1);
                    end
                end
                idle_cyc = 0;
                mon_idle = 1'b1;
            end else begin
                idle_cyc++;
                chk("idle.busy", 32'(BUSY), 32'd0);
                chk("idle.gates", 32'({R_GATES_, W_GATES_, C_GATES}), 32'({7'h7F, 6'h3F, 6'h00}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b0;

        // Reset with both requesters active: outputs inert, CT granted on the
        // first edge after release, SQ follows back-to-back.
        push_ct(3'd3, 6'h04);
        push_sq(3'd1, 6'h02);
        expect_xfer("rst_ct", 1'b1, 1'b0, 6'h00, 7'h7B, 6'h3B);
        expect_xfer("rst_sq", 1'b0, 1'b1, 6'h02, 7'h7E, 6'h3D);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst.r", 32'(R_GATES_), 32'h7F);
        chk("rst.w", 32'(W_GATES_), 32'h3F);
        chk("rst.c", 32'(C_GATES), 32'h00);
        chk("rst.acks", 32'({SQ_ACK, CT_ACK}), 32'h0);
        chk("rst.busy", 32'(BUSY), 32'd0);
        rst = 1'b1;
        @(posedge CLOCK); #1;
        chk("rst.first_grant", 32'(CT_ACK), 32'd1);
        wait_drain("rst");

        // Single SQ transfer A -> {L,Q}.
        @(negedge CLOCK);
        push_sq(3'd1, 6'h06);
        expect_xfer("single", 1'b0, 1'b0, 6'h06, 7'h7E, 6'h39);
        wait_drain("single");

        // Self-transfer A -> A: clear masked.
        @(negedge CLOCK);
        push_sq(3'd1, 6'h01);
        expect_xfer("self", 1'b0, 1'b0, 6'h00, 7'h7E, 6'h3E);
        wait_drain("self");

        // SQ stream: no-op, C -> all, G -> all (G masked), back to back.
        @(negedge CLOCK);
        push_sq(3'd0, 6'h00);
        push_sq(3'd7, 6'h3F);
        push_sq(3'd5, 6'h3F);
        expect_xfer("noop",  1'b0, 1'b0, 6'h00, 7'h7F, 6'h3F);
        expect_xfer("c_all", 1'b0, 1'b1, 6'h3F, 7'h3F, 6'h00);
        expect_xfer("g_all", 1'b0, 1'b1, 6'h1F, 7'h6F, 6'h00);
        wait_drain("stream");

        // CT alone, U -> B.
        @(negedge CLOCK);
        push_ct(3'd6, 6'h10);
        expect_xfer("ct_u", 1'b1, 1'b0, 6'h10, 7'h5F, 6'h2F);
        wait_drain("ct_u");

        // Simultaneous: CT Z -> G first, then SQ L -> A without an IDLE gap.
        @(negedge CLOCK);
        push_ct(3'd4, 6'h20);
        push_sq(3'd2, 6'h01);
        expect_xfer("sim_ct", 1'b1, 1'b0, 6'h20, 7'h77, 6'h1F);
        expect_xfer("sim_sq", 1'b0, 1'b1, 6'h01, 7'h7D, 6'h3E);
        wait_drain("simul");

        // Continuous CT with SQ waiting.
        @(negedge CLOCK);
        for (int i = 0; i < 5; i++) push_ct(3'd3, 6'h08);
        push_sq(3'd4, 6'h01);
`ifdef WL_XFER_FAIRNESS_EN
        expect_xfer("fair_ct1", 1'b1, 1'b0, 6'h08, 7'h7B, 6'h37);
        expect_xfer("fair_ct2", 1'b1, 1'b1, 6'h08, 7'h7B, 6'h37);
        expect_xfer("fair_ct3", 1'b1, 1'b1, 6'h08, 7'h7B, 6'h37);
        expect_xfer("fair_sq",  1'b0, 1'b1, 6'h01, 7'h77, 6'h3E);
        expect_xfer("fair_ct4", 1'b1, 1'b1, 6'h08, 7'h7B, 6'h37);
        expect_xfer("fair_ct5", 1'b1, 1'b1, 6'h08, 7'h7B, 6'h37);
`else
        for (int i = 0; i < 5; i++) expect_xfer("prio_ct", 1'b1, (i != 0), 6'h08, 7'h7B, 6'h37);
        expect_xfer("prio_sq", 1'b0, 1'b1, 6'h01, 7'h77, 6'h3E);
`endif
        wait_drain("fair");

        // Reset during CT's WR: gates drop at once, SQ is granted after release.
        @(negedge CLOCK);
        push_ct(3'd7, 6'h01);
        push_sq(3'd1, 6'h04);
        expect_xfer("wrrst_ct", 1'b1, 1'b0, 6'h01, 7'h3F, 6'h3E);
        expect_xfer("wrrst_sq", 1'b0, 1'b0, 6'h04, 7'h7E, 6'h3B);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge CLOCK); #1;
                if (CT_ACK) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wrrst.ct_ack_seen", 32'(seen), 32'd1);
        end
        @(posedge CLOCK);
        @(posedge CLOCK);
        @(negedge CLOCK);
        #1 rst = 1'b0;
        #1;
        chk("wrrst.r", 32'(R_GATES_), 32'h7F);
        chk("wrrst.w", 32'(W_GATES_), 32'h3F);
        chk("wrrst.c", 32'(C_GATES), 32'h00);
        chk("wrrst.busy", 32'(BUSY), 32'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        rst = 1'b1;
        @(posedge CLOCK); #1;
        chk("wrrst.regrant", 32'(SQ_ACK), 32'd1);
        wait_drain("wrrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wl_xfer_seq.md
# wl_xfer_seq

Register-transfer sequencer for the four-bit arithmetic slices. It takes one decoded transfer at a time (source register → destination set) from either of two requesters and plays out the clear / read / write control-pulse sequence on the slices' active-low read gates, active-low write gates and active-high clear lines. It sits between the control-pulse decode and the module gate inputs. The counter-increment requester has priority over the instruction sequencer.

## Interface
Parameters:
- HOLD_CYCLES, 1, number of cycles the write gates are held (1..4).

Ports:
- CLOCK  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- SQ_REQ  in  1  instruction-sequencer transfer request.
- SQ_SRC  in  3  source code: 0 none, 1 A, 2 L, 3 Q, 4 Z, 5 G, 6 U, 7 C.
- SQ_DST  in  6  destination mask, bits {G,B,Z,Q,L,A} = [5:0].
- SQ_ACK  out  1  one-cycle grant pulse for SQ.
- CT_REQ, CT_SRC, CT_DST, CT_ACK: same as SQ_*, for the counter-increment requester.
- R_GATES_  out  7  {RCG_,RUG_,RGG_,RZG_,RQG_,RLG_,RAG_}, active low.
- W_GATES_  out  6  {WG1G_,WBG_,WZG_,WQG_,WLG_,WAG_}, active low.
- C_GATES  out  6  {CGG,CBG,CZG,CQG,CLG1G,CAG}, active high.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE → CLR → RD → WR (HOLD_CYCLES cycles) → IDLE or CLR.
- Grant sampling happens only at a rising edge while in IDLE, or at the last WR edge.
  - If any REQ is high, the winner's SRC/DST are latched, ACK of the winner is high for the next cycle, and the state becomes CLR.
- CLR: C_GATES = latched DST, except that a DST bit naming the latched source register is masked (A→A, L→L, Q→Q, Z→Z, G→G do not clear the source).
- RD: the R_GATES_ bit for SRC is low. SRC = 0 drives no read gate, so a zero word is written.
- WR: the R_GATES_ bit stays low, and W_GATES_ = ~DST.
- DST = 0 or SRC = 0 is legal. Both zero is a legal no-op transfer: it is acked and sequenced, and no gates are asserted.
- Arbitration: CT wins over SQ. A streak counter (2 bits) counts consecutive CT grants while SQ_REQ is high. At 3, the next grant goes to SQ and the counter clears. The counter also clears on any SQ grant or whenever SQ_REQ is low at a grant point.
- Requesters hold REQ/SRC/DST stable until ACK is seen, and drop REQ at the edge ending the ACK cycle.
- Reset values: R_GATES_ = 7'h7F, W_GATES_ = 6'h3F, C_GATES = 0, ACKs = 0, BUSY = 0, state IDLE, streak counter 0.

## Timing
- REQ high at edge k (IDLE):
  - cycle k+1: ACK = 1, CLR.
  - cycle k+2: RD.
  - cycles k+3 … k+2+HOLD_CYCLES: WR.
- Back-to-back throughput is 2 + HOLD_CYCLES cycles per transfer. A request pending at the last WR edge enters CLR in the very next cycle, with no IDLE gap.
- All gate outputs are registered and glitch-free. No output is combinational from a REQ input.
- A CLR cycle never overlaps a read or write gate. Read gates always lead write gates by exactly one cycle.
- rst low in any state forces the reset values asynchronously. An in-flight transfer is abandoned, with no ACK replay. A requester whose ACK had not yet been seen keeps requesting.
- SQ_REQ and CT_REQ rising in the same IDLE cycle: CT is granted, unless the streak counter is at 3.

## Configuration
- WL_XFER_FAIRNESS_EN defined: the streak counter and forced SQ grant are present, as described above.
- Not defined: strict CT priority. The streak counter is removed, and SQ can starve under continuous CT requests.

## Structure
- Package wl_xfer_pkg contains:
  - the source-code enum (NONE, A, L, Q, Z, G, U, C);
  - DST bit index constants;
  - the state enum;
  - FAIR_LIMIT = 3;
  - a function mapping a source code to its overlapping DST bit (U, C and NONE map to none).
- One sub-module, wl_xfer_arb, implements the two-way priority arbiter plus streak counter. It is instantiated at the grant points.

## Test plan
- Reset: hold rst low with both REQs high. Required: R_GATES_ = 7F, W_GATES_ = 3F, C_GATES = 0, no ACK. Release rst, and the first grant follows at the next edge.
- Single SQ transfer, SRC = 1 (A), DST = 6'b000110 (L,Q), HOLD_CYCLES = 1. Required: CLR cycle C_GATES = 06; RD cycle R_GATES_ = 7E; WR cycle R_GATES_ = 7E and W_GATES_ = 39; BUSY high for 3 cycles.
- Self-transfer, SRC = 1, DST = 6'b000001. Required: C_GATES = 0 during CLR; WAG_ and RAG_ both low during WR.
- Simultaneous requests, CT(SRC = 4, DST = 0x20) and SQ(SRC = 2, DST = 0x01). Required: CT_ACK first; SQ_ACK at the CT transfer's last WR edge + 1; no IDLE gap.
- Fairness (macro defined): CT_REQ continuously high with SQ_REQ high. Required grant order CT, CT, CT, SQ, CT… Without the macro, SQ is never acked.
- Reset asserted during WR. Required: gates go inactive immediately; after release the sequencer is IDLE and re-grants the still-pending requester.
